// File: rtl/amoeba_pkg.sv
// Shared types and constants for the amoeba SAT core: FSM state encoding,
// LFSR feedback taps, the per-variable seed spread and a counter width helper.
package amoeba_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SOLVED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    // Right-shift Galois feedback mask for the 32-bit LFSRs
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

    // Golden-ratio constant used to spread the base seed across variables
    localparam logic [31:0] SEED_SPREAD = 32'h9E37_79B9;

    // Bits needed to hold values 0..n inclusive (at least one bit)
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/amoeba_lfsr32.sv
// 32-bit right-shift Galois LFSR with a seed parameter and an advance enable.
// Only the low OUT_W bits are exported; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module amoeba_lfsr32
    import amoeba_pkg::*;
#(
    parameter logic [31:0] SEED_VAL = 32'h0000_0001,
    parameter int          OUT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [OUT_W-1:0] state_o
);

    localparam logic [31:0] SEED_SAFE = (SEED_VAL == 32'h0) ? 32'h1 : SEED_VAL;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next state: shift right, fold the taps in when the outgoing bit is 1
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    // State register, returns to the seed on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_SAFE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/amoeba_core.sv
// amoeba_core: variable register bank, per-variable stochastic gates
// (SG1/SG2/SG3) driven by private LFSRs, unsat counting with global minimum
// tracking, stagnation-driven threshold reseed and start/done control.
// The clause/variable-cell network is external and combinational from x and
// contra_q.
// Optional build macro AMOEBA_BEST_SNAPSHOT_EN adds the best_x output, a
// snapshot of the assignment that produced the latest strict unsat minimum.
module amoeba_core
    import amoeba_pkg::*;
#(
    parameter int          NUM_VARIABLES = 50,
    parameter int          NUM_CLAUSES   = 80,
    parameter int          PROB_W        = 10,
    parameter int          STALE_LIMIT   = 100000,
    parameter int          MAX_STEPS     = (1 << 24) - 1,
    parameter logic [31:0] SEED          = 32'hACE1_2F3B
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [PROB_W-1:0]               sg1_init,
    input  logic [PROB_W-1:0]               sg2_init,
    input  logic [PROB_W-1:0]               sg3_init,
    input  logic [NUM_VARIABLES-1:0]        inter,
    input  logic [NUM_VARIABLES-1:0]        inter_n,
    input  logic [NUM_VARIABLES-1:0]        contra_next,
    input  logic [NUM_VARIABLES-1:0]        contra_mrg,
    input  logic [NUM_CLAUSES-1:0]          clause_sat,
    output logic [NUM_VARIABLES-1:0]        x,
    output logic [NUM_VARIABLES-1:0]        contra_q,
    output logic                            busy,
    output logic                            solved,
    output logic                            timeout,
    output logic                            declining,
    output logic [cnt_w(NUM_CLAUSES)-1:0]   unsat_count,
    output logic [cnt_w(NUM_CLAUSES)-1:0]   best_unsat,
    output logic [23:0]                     step_count
`ifdef AMOEBA_BEST_SNAPSHOT_EN
    ,
    output logic [NUM_VARIABLES-1:0]        best_x
`endif
);

    localparam int UW = cnt_w(NUM_CLAUSES);
    localparam int SW = cnt_w(STALE_LIMIT);
    localparam int RW = 3 * PROB_W;

    state_t                   state_q;
    logic [NUM_VARIABLES-1:0] x_q;
    logic [NUM_VARIABLES-1:0] x_d;
    logic [NUM_VARIABLES-1:0] x_seed;
    logic [NUM_VARIABLES-1:0] contra_st_q;
    logic [PROB_W-1:0]        sg1_q;
    logic [PROB_W-1:0]        sg2_q;
    logic [PROB_W-1:0]        sg3_q;
    logic [23:0]              step_q;
    logic [23:0]              step_d;
    logic [SW-1:0]            stale_q;
    logic [SW-1:0]            stale_d;
    logic [UW-1:0]            unsat_q;
    logic [UW-1:0]            unsat_d;
    logic [UW-1:0]            best_q;
    logic [UW-1:0]            sat_cnt;
    logic                     solved_q;
    logic                     timeout_q;
    logic                     declining_q;
    logic                     all_sat;
    logic [RW-1:0]            g_rnd;

    // Per-variable LFSR and stochastic gates feeding the majority update
    genvar gi;
    for (gi = 0; gi < NUM_VARIABLES; gi++) begin : g_var
        localparam logic [31:0] VAR_SEED = SEED ^ (32'(gi) * SEED_SPREAD);

        logic [RW-1:0] rnd;
        logic          f1s;
        logic          f0s;
        logic          fl;
        logic          fb;

        amoeba_lfsr32 #(
            .SEED_VAL (VAR_SEED),
            .OUT_W    (RW)
        ) u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .en_i    (1'b1),
            .state_o (rnd)
        );

        assign f1s        = inter[gi] | (rnd[PROB_W-1:0] < sg1_q);
        assign f0s        = inter_n[gi] & ~(rnd[2*PROB_W-1:PROB_W] < sg2_q);
        assign fl         = contra_mrg[gi] & ~(rnd[RW-1:2*PROB_W] < sg3_q);
        assign fb         = ~x_q[gi] ^ fl;
        assign x_d[gi]    = (f1s & f0s) | (f1s & fb) | (f0s & fb);
        assign x_seed[gi] = rnd[0];
    end

    // Global LFSR that supplies fresh SG thresholds on stagnation
    amoeba_lfsr32 #(
        .SEED_VAL (SEED ^ (32'(NUM_VARIABLES) * SEED_SPREAD)),
        .OUT_W    (RW)
    ) u_glfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (1'b1),
        .state_o (g_rnd)
    );

    // Unsat count of the current x plus step and stale increments
    always_comb begin
        sat_cnt = '0;
        for (int c = 0; c < NUM_CLAUSES; c++) begin
            sat_cnt = sat_cnt + UW'(clause_sat[c]);
        end
        unsat_d = UW'(NUM_CLAUSES) - sat_cnt;
        all_sat = &clause_sat;
        step_d  = step_q + 24'd1;
        stale_d = stale_q + SW'(1);
    end

    // Control FSM with all datapath registers; solved > timeout > reseed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            contra_st_q <= '0;
            sg1_q       <= '0;
            sg2_q       <= '0;
            sg3_q       <= '0;
            step_q      <= '0;
            stale_q     <= '0;
            unsat_q     <= UW'(NUM_CLAUSES);
            best_q      <= UW'(NUM_CLAUSES);
            solved_q    <= 1'b0;
            timeout_q   <= 1'b0;
            declining_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    step_q  <= step_d;
                    unsat_q <= unsat_d;
                    if (unsat_d < best_q) begin
                        best_q <= unsat_d;
                    end
                    if (all_sat) begin
                        // Freeze x and contra_q at the satisfying assignment
                        state_q  <= ST_SOLVED;
                        solved_q <= 1'b1;
                        unsat_q  <= '0;
                    end else if (step_d == 24'(MAX_STEPS)) begin
                        state_q   <= ST_TIMEOUT;
                        timeout_q <= 1'b1;
                    end else begin
                        x_q         <= x_d;
                        contra_st_q <= ~contra_next;
                        if (unsat_d < unsat_q) begin
                            stale_q     <= '0;
                            declining_q <= 1'b0;
                        end else if (stale_d == SW'(STALE_LIMIT)) begin
                            sg1_q       <= g_rnd[PROB_W-1:0];
                            sg2_q       <= g_rnd[2*PROB_W-1:PROB_W];
                            sg3_q       <= g_rnd[RW-1:2*PROB_W];
                            stale_q     <= '0;
                            declining_q <= 1'b1;
                        end else begin
                            stale_q <= stale_d;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        x_q         <= x_seed;
                        sg1_q       <= sg1_init;
                        sg2_q       <= sg2_init;
                        sg3_q       <= sg3_init;
                        contra_st_q <= '0;
                        step_q      <= '0;
                        stale_q     <= '0;
                        best_q      <= UW'(NUM_CLAUSES);
                        solved_q    <= 1'b0;
                        timeout_q   <= 1'b0;
                        declining_q <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef AMOEBA_BEST_SNAPSHOT_EN
    logic [NUM_VARIABLES-1:0] best_x_q;

    // Capture the assignment that produced each new strict minimum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_x_q <= '0;
        end else if (state_q != ST_RUN) begin
            if (start) begin
                best_x_q <= '0;
            end
        end else if (unsat_d < best_q) begin
            best_x_q <= x_q;
        end
    end

    assign best_x = best_x_q;
`endif

    assign x           = x_q;
    assign contra_q    = contra_st_q;
    assign busy        = (state_q == ST_RUN);
    assign solved      = solved_q;
    assign timeout     = timeout_q;
    assign declining   = declining_q;
    assign unsat_count = unsat_q;
    assign best_unsat  = best_q;
    assign step_count  = step_q;

endmodule

// File: tb/tb_amoeba_core.sv
// Directed self-checking bench for amoeba_core. Instance A: 3 variables,
// 80 clauses (77 padding clauses always satisfied), STALE_LIMIT=8.
// Instance B: 1 variable, unsatisfiable (x1)&(~x1), MAX_STEPS=20.
// Build with AMOEBA_BEST_SNAPSHOT_EN to also exercise best_x.
module tb_amoeba_core;

    localparam logic [2:0] TARGET  = 3'b101;
    localparam logic [2:0] FORCE_X = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [9:0] sg1_init = '0;
    logic [9:0] sg2_init = '0;
    logic [9:0] sg3_init = '0;

    // Instance A signals
    logic [2:0]  inter_a, inter_n_a, contra_mrg_a;
    logic [2:0]  contra_next_a = 3'b000;
    logic [79:0] clause_sat_a;
    logic [2:0]  x_a, contra_q_a;
    logic        busy_a, solved_a, timeout_a, declining_a;
    logic [6:0]  unsat_a, best_a;
    logic [23:0] step_a;
    logic [2:0]  real3;
    logic [1:0]  net_mode = 2'd0;

    // Instance B signals
    logic [0:0]  inter_b, inter_n_b, contra_mrg_b;
    logic [0:0]  contra_next_b = 1'b1;
    logic [1:0]  clause_sat_b;
    logic [0:0]  x_b, contra_q_b;
    logic        busy_b, solved_b, timeout_b, declining_b;
    logic [1:0]  unsat_b, best_b;
    logic [23:0] step_b;

`ifdef AMOEBA_BEST_SNAPSHOT_EN
    logic [2:0]  best_x_a;
    logic [0:0]  best_x_b;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    amoeba_core #(
        .NUM_VARIABLES (3),
        .NUM_CLAUSES   (80),
        .PROB_W        (10),
        .STALE_LIMIT   (8)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .sg1_init    (sg1_init),
        .sg2_init    (sg2_init),
        .sg3_init    (sg3_init),
        .inter       (inter_a),
        .inter_n     (inter_n_a),
        .contra_next (contra_next_a),
        .contra_mrg  (contra_mrg_a),
        .clause_sat  (clause_sat_a),
        .x           (x_a),
        .contra_q    (contra_q_a),
        .busy        (busy_a),
        .solved      (solved_a),
        .timeout     (timeout_a),
        .declining   (declining_a),
        .unsat_count (unsat_a),
        .best_unsat  (best_a),
        .step_count  (step_a)
`ifdef AMOEBA_BEST_SNAPSHOT_EN
        ,
        .best_x      (best_x_a)
`endif
    );

    amoeba_core #(
        .NUM_VARIABLES (1),
        .NUM_CLAUSES   (2),
        .PROB_W        (10),
        .MAX_STEPS     (20)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .sg1_init    (sg1_init),
        .sg2_init    (sg2_init),
        .sg3_init    (sg3_init),
        .inter       (inter_b),
        .inter_n     (inter_n_b),
        .contra_next (contra_next_b),
        .contra_mrg  (contra_mrg_b),
        .clause_sat  (clause_sat_b),
        .x           (x_b),
        .contra_q    (contra_q_b),
        .busy        (busy_b),
        .solved      (solved_b),
        .timeout     (timeout_b),
        .declining   (declining_b),
        .unsat_count (unsat_b),
        .best_unsat  (best_b),
        .step_count  (step_b)
`ifdef AMOEBA_BEST_SNAPSHOT_EN
        ,
        .best_x      (best_x_b)
`endif
    );

    // Bench network for A. Mode 0: walk x toward TARGET via the flip path;
    // mode 1/2: force x to FORCE_X, 1 or 2 clauses unsat; mode 3: drive x to 0.
    always_comb begin
        real3        = {(~x_a[1] | ~x_a[2]), (~x_a[0] | x_a[2]), (x_a[0] | x_a[1])};
        inter_a      = 3'b111;
        inter_n_a    = 3'b000;
        contra_mrg_a = ~(x_a ^ TARGET);
        clause_sat_a = {{77{1'b1}}, real3};
        case (net_mode)
            2'd1: begin
                inter_a      = FORCE_X;
                inter_n_a    = FORCE_X;
                contra_mrg_a = 3'b000;
                clause_sat_a = {{79{1'b1}}, 1'b0};
            end
            2'd2: begin
                inter_a      = FORCE_X;
                inter_n_a    = FORCE_X;
                contra_mrg_a = 3'b000;
                clause_sat_a = {{78{1'b1}}, 2'b00};
            end
            2'd3: begin
                inter_a      = 3'b000;
                inter_n_a    = 3'b000;
                contra_mrg_a = 3'b000;
            end
            default: ;
        endcase
    end

    // Bench network for B: (x1)&(~x1), exactly one clause always satisfied
    always_comb begin
        clause_sat_b = {~x_b[0], x_b[0]};
        inter_b      = 1'b0;
        inter_n_b    = 1'b0;
        contra_mrg_b = 1'b0;
    end

    function automatic logic clause_ok(input logic [2:0] v);
        return (v[0] | v[1]) & (~v[0] | v[2]) & (~v[1] | ~v[2]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++; if (x_a !== 3'b000) begin tests_failed++; $display("FAIL reset_x got=%b exp=000", x_a); end
        tests_run++; if (contra_q_a !== 3'b000) begin tests_failed++; $display("FAIL reset_contra got=%b exp=000", contra_q_a); end
        tests_run++; if ({busy_a, solved_a, timeout_a, declining_a} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got=%b exp=0000", {busy_a, solved_a, timeout_a, declining_a}); end
        tests_run++; if (unsat_a !== 7'd80) begin tests_failed++; $display("FAIL reset_unsat got=%0d exp=80", unsat_a); end
        tests_run++; if (best_a !== 7'd80) begin tests_failed++; $display("FAIL reset_best got=%0d exp=80", best_a); end
        tests_run++; if (step_a !== 24'd0) begin tests_failed++; $display("FAIL reset_step got=%0d exp=0", step_a); end
        tests_run++; if (unsat_b !== 2'd2) begin tests_failed++; $display("FAIL reset_unsat_b got=%0d exp=2", unsat_b); end
`ifdef AMOEBA_BEST_SNAPSHOT_EN
        tests_run++; if (best_x_a !== 3'b000) begin tests_failed++; $display("FAIL reset_best_x got=%b exp=000", best_x_a); end
`endif
        $display("[TB] test_reset done");
    endtask

    task automatic test_solve();
        int n;
        net_mode      = 2'd0;
        contra_next_a = 3'b010;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL solve_busy_after_start got=%b exp=1", busy_a); end
        tests_run++; if (step_a !== 24'd0) begin tests_failed++; $display("FAIL solve_step_after_start got=%0d exp=0", step_a); end
        n = 0;
        while (solved_a !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        tests_run++; if (solved_a !== 1'b1) begin tests_failed++; $display("FAIL solve_within_64 got=%b exp=1", solved_a); end
        tests_run++; if (clause_ok(x_a) !== 1'b1) begin tests_failed++; $display("FAIL solve_x_sat x=%b sat=%b exp=1", x_a, clause_ok(x_a)); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL solve_busy got=%b exp=0", busy_a); end
        tests_run++; if (unsat_a !== 7'd0) begin tests_failed++; $display("FAIL solve_unsat got=%0d exp=0", unsat_a); end
        tests_run++; if (best_a !== 7'd0) begin tests_failed++; $display("FAIL solve_best got=%0d exp=0", best_a); end
`ifdef AMOEBA_BEST_SNAPSHOT_EN
        tests_run++; if (clause_ok(best_x_a) !== 1'b1) begin tests_failed++; $display("FAIL solve_best_x best_x=%b sat=%b exp=1", best_x_a, clause_ok(best_x_a)); end
`endif
        // Network now pushes x to 000 and contra toward 111; both must stay frozen
        net_mode      = 2'd3;
        contra_next_a = 3'b000;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++; if (solved_a !== 1'b1 || clause_ok(x_a) !== 1'b1) begin tests_failed++; $display("FAIL solve_frozen cyc=%0d solved=%b x=%b exp solved=1 x satisfying", k, solved_a, x_a); end
            tests_run++; if (contra_q_a === 3'b111) begin tests_failed++; $display("FAIL solve_contra_frozen cyc=%0d got=%b exp not 111", k, contra_q_a); end
        end
        $display("[TB] test_solve: solved after %0d cycles x=%b", n, x_a);
    endtask

    task automatic test_start_in_solved();
        int n;
        net_mode = 2'd0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tests_run++; if (solved_a !== 1'b0) begin tests_failed++; $display("FAIL restart_solved got=%b exp=0", solved_a); end
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL restart_busy got=%b exp=1", busy_a); end
        tests_run++; if (best_a !== 7'd80) begin tests_failed++; $display("FAIL restart_best got=%0d exp=80", best_a); end
        n = 0;
        while (solved_a !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        tests_run++; if (solved_a !== 1'b1) begin tests_failed++; $display("FAIL restart_resolve got=%b exp=1", solved_a); end
        $display("[TB] test_start_in_solved: re-solved after %0d cycles", n);
    endtask

    task automatic test_stale();
        net_mode      = 2'd1;
        contra_next_a = 3'b011;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tests_run++; if (declining_a !== 1'b0) begin tests_failed++; $display("FAIL stale_decl_start got=%b exp=0", declining_a); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            tests_run++; if (step_a !== 24'(k)) begin tests_failed++; $display("FAIL stale_step k=%0d got=%0d exp=%0d", k, step_a, k); end
            tests_run++; if (declining_a !== 1'b0) begin tests_failed++; $display("FAIL stale_decl_early k=%0d got=%b exp=0", k, declining_a); end
            if (k == 1) begin
                tests_run++; if (x_a !== FORCE_X) begin tests_failed++; $display("FAIL stale_x_force got=%b exp=%b", x_a, FORCE_X); end
                tests_run++; if (unsat_a !== 7'd1) begin tests_failed++; $display("FAIL stale_unsat got=%0d exp=1", unsat_a); end
                tests_run++; if (best_a !== 7'd1) begin tests_failed++; $display("FAIL stale_best got=%0d exp=1", best_a); end
                tests_run++; if (contra_q_a !== 3'b100) begin tests_failed++; $display("FAIL stale_contra got=%b exp=100", contra_q_a); end
            end
        end
        tick();
        tests_run++; if (declining_a !== 1'b1) begin tests_failed++; $display("FAIL stale_reseed_decl got=%b exp=1", declining_a); end
        tests_run++; if (dut_a.stale_q !== '0) begin tests_failed++; $display("FAIL stale_counter_clear got=%0d exp=0", dut_a.stale_q); end
        tests_run++; if ({dut_a.sg1_q, dut_a.sg2_q, dut_a.sg3_q} === 30'd0) begin tests_failed++; $display("FAIL stale_sg_change got=0 exp nonzero"); end
        tests_run++; if (step_a !== 24'd8) begin tests_failed++; $display("FAIL stale_step8 got=%0d exp=8", step_a); end
        // Worse step keeps declining; the following strict improvement clears it
        net_mode = 2'd2;
        tick();
        tests_run++; if (unsat_a !== 7'd2 || declining_a !== 1'b1) begin tests_failed++; $display("FAIL stale_worse unsat=%0d decl=%b exp unsat=2 decl=1", unsat_a, declining_a); end
        net_mode = 2'd1;
        tick();
        tests_run++; if (unsat_a !== 7'd1 || declining_a !== 1'b0) begin tests_failed++; $display("FAIL stale_improve unsat=%0d decl=%b exp unsat=1 decl=0", unsat_a, declining_a); end
        tests_run++; if (best_a !== 7'd1) begin tests_failed++; $display("FAIL stale_best_hold got=%0d exp=1", best_a); end
        $display("[TB] test_stale: reseed observed, step=%0d", step_a);
    endtask

    task automatic test_start_ignored();
        start_a = 1'b1; tick(); start_a = 1'b0;
        tests_run++; if (step_a !== 24'd11) begin tests_failed++; $display("FAIL ignore_step got=%0d exp=11", step_a); end
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL ignore_busy got=%b exp=1", busy_a); end
        tests_run++; if (best_a !== 7'd1) begin tests_failed++; $display("FAIL ignore_best got=%0d exp=1", best_a); end
        $display("[TB] test_start_ignored: step=%0d", step_a);
    endtask

    task automatic test_timeout();
        start_b = 1'b1; tick(); start_b = 1'b0;
        tests_run++; if (busy_b !== 1'b1 || step_b !== 24'd0) begin tests_failed++; $display("FAIL tmo_start busy=%b step=%0d exp busy=1 step=0", busy_b, step_b); end
        for (int k = 0; k < 19; k++) tick();
        tests_run++; if (step_b !== 24'd19 || timeout_b !== 1'b0 || busy_b !== 1'b1) begin tests_failed++; $display("FAIL tmo_before step=%0d tmo=%b busy=%b exp 19/0/1", step_b, timeout_b, busy_b); end
        tick();
        tests_run++; if (timeout_b !== 1'b1) begin tests_failed++; $display("FAIL tmo_flag got=%b exp=1", timeout_b); end
        tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL tmo_busy got=%b exp=0", busy_b); end
        tests_run++; if (step_b !== 24'd20) begin tests_failed++; $display("FAIL tmo_step got=%0d exp=20", step_b); end
        tests_run++; if (best_b !== 2'd1 || unsat_b !== 2'd1) begin tests_failed++; $display("FAIL tmo_counts best=%0d unsat=%0d exp 1/1", best_b, unsat_b); end
        tests_run++; if (solved_b !== 1'b0) begin tests_failed++; $display("FAIL tmo_solved got=%b exp=0", solved_b); end
        for (int k = 0; k < 3; k++) tick();
        tests_run++; if (step_b !== 24'd20 || timeout_b !== 1'b1) begin tests_failed++; $display("FAIL tmo_hold step=%0d tmo=%b exp 20/1", step_b, timeout_b); end
        $display("[TB] test_timeout: timeout at step %0d", step_b);
    endtask

    task automatic test_async_reset();
        tick();
        #3 rst = 1'b1;
        #1;
        tests_run++; if (x_a !== 3'b000) begin tests_failed++; $display("FAIL areset_x got=%b exp=000", x_a); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL areset_busy got=%b exp=0", busy_a); end
        tests_run++; if (unsat_a !== 7'd80) begin tests_failed++; $display("FAIL areset_unsat got=%0d exp=80", unsat_a); end
        tests_run++; if (step_a !== 24'd0 || declining_a !== 1'b0) begin tests_failed++; $display("FAIL areset_state step=%0d decl=%b exp 0/0", step_a, declining_a); end
        tests_run++; if (timeout_b !== 1'b0) begin tests_failed++; $display("FAIL areset_tmo_b got=%b exp=0", timeout_b); end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        #2 rst = 1'b1;
        #20;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_solve();
        test_start_in_solved();
        test_stale();
        test_start_ignored();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/amoeba_core.md
# amoeba_core

Parametrised, synthesizable successor to the amoeba SAT-solver top level. It holds the variable register bank and the three stochastic gates (SG1/SG2/SG3) per variable, all driven by on-chip LFSRs. It also counts unsatisfied clauses, tracks the global minimum, adapts SG thresholds on stagnation, and reports solved/timeout through a start/done handshake. The generated clause/variable-cell network (inter, inter_n, contra, clause outputs) sits outside this block and is purely combinational from `x` and `contra_q`.

## Interface
Parameters:
- `NUM_VARIABLES`, 50: number of variables.
- `NUM_CLAUSES`, 80: number of clauses.
- `PROB_W`, 10: SG threshold width; probability is threshold / 2^PROB_W.
- `STALE_LIMIT`, 100000: non-improving steps before SG reseed.
- `MAX_STEPS`, 2^24-1: step budget before timeout.
- `SEED`, 32'hACE1_2F3B: base LFSR seed, nonzero.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; accepted in any state except RUN.
- `sg1_init`, `sg2_init`, `sg3_init` in PROB_W each: thresholds loaded on start.
- `inter` in NUM_VARIABLES: F1 from network.
- `inter_n` in NUM_VARIABLES: F0 from network.
- `contra_next` in NUM_VARIABLES: contra(t+1) from network.
- `contra_mrg` in NUM_VARIABLES: merged contra from network.
- `clause_sat` in NUM_CLAUSES: 1 = clause satisfied by current `x`.
- `x` out NUM_VARIABLES: variable assignment.
- `contra_q` out NUM_VARIABLES: registered ~contra_next.
- `busy`, `solved`, `timeout`, `declining` out 1 each.
- `unsat_count`, `best_unsat` out $clog2(NUM_CLAUSES+1) each.
- `step_count` out 24.

## Operation
- States: IDLE, RUN, SOLVED, TIMEOUT. `busy` is 1 only in RUN.
- `start` outside RUN moves the block to RUN and:
  - loads `x` from per-variable LFSR bit 0;
  - loads the SG thresholds from `sg*_init`;
  - clears `contra_q`, `step_count` and the stale counter;
  - sets `best_unsat` to NUM_CLAUSES and clears `solved`, `timeout` and `declining`.
- `start` during RUN is ignored.
- RUN, every cycle, for variable i. Each variable has its own 32-bit Galois LFSR (seed = SEED ^ i*32'h9E3779B9). r1, r2 and r3 are the PROB_W-bit fields [PROB_W-1:0], [2*PROB_W-1:PROB_W] and [3*PROB_W-1:2*PROB_W].
  - f1s = inter[i] | (r1 < sg1)
  - f0s = inter_n[i] & ~(r2 < sg2)
  - fl = contra_mrg[i] & ~(r3 < sg3)
  - x[i] <= MAJ(f1s, f0s, ~x[i] ^ fl)
  - contra_q[i] <= ~contra_next[i]
  - step_count increments.
- Counting, every RUN cycle:
  - `unsat_count` <= NUM_CLAUSES - popcount(clause_sat).
  - `best_unsat` <= min(best_unsat, new unsat).
- Stale detection:
  - new unsat >= previous `unsat_count`: stale counter increments.
  - Strict improvement: stale counter is cleared and `declining` drops to 0.
  - Counter reaching STALE_LIMIT: sg1..sg3 are reloaded from a separate global LFSR (three PROB_W fields), the counter clears, and `declining` is set to 1.
- Solved: when `clause_sat` is all ones at a RUN edge:
  - `x` and `contra_q` are not updated on that edge (frozen at the solution);
  - the state moves to SOLVED, `solved` is set and `unsat_count` is set to 0.
- Timeout: when step_count reaches MAX_STEPS at a RUN edge (and the solved condition is not true), the state moves to TIMEOUT, `timeout` is set and `x` is held.
- Precedence on the same edge: solved > timeout > stale reseed.
- LFSRs advance every cycle in all states, including IDLE, so restarts see fresh randomness.

## Timing
- Reset values:
  - state IDLE; `x` = 0; `contra_q` = 0;
  - all flags 0; `unsat_count` = `best_unsat` = NUM_CLAUSES; `step_count` = 0;
  - LFSRs hold their seeds.
- Start latency: the `start` edge loads; the first `x` update happens on the next edge.
- `unsat_count` lags `x` by one cycle (popcount is taken before the edge that updates `x`).
- `solved` asserts on the same edge that freezes the satisfying `x`.
- `rst` mid-RUN aborts immediately to the reset values.

## Configuration
- `AMOEBA_BEST_SNAPSHOT_EN` defined: adds output `best_x` (NUM_VARIABLES).
  - `best_x` captures the current `x` whenever a new strict minimum of unsat is seen.
  - Cleared to 0 on reset and on start.
- Undefined: no `best_x` port and no snapshot register.

## Structure
- Package `amoeba_pkg`:
  - state enum;
  - LFSR taps constant (32'h80200003);
  - golden-ratio seed-spread constant;
  - a `cnt_w(n)` width function.
- Sub-module `amoeba_lfsr32`: 32-bit Galois LFSR with seed parameter and enable. It is instantiated NUM_VARIABLES+1 times.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `x`=0, `busy`=0, `unsat_count`=80 with no clock edge needed.
- 3-var instance (x1|x2)&(~x1|x3)&(~x2|~x3), sg=0/0/0 -> within 64 cycles `solved`=1, `x` satisfies all three clauses and stays frozen for 10 further cycles.
- Bench network forces `clause_sat` = 79 ones, STALE_LIMIT=8 -> reseed after 8 non-improving steps, `declining`=1, sg registers change, stale counter clears.
- MAX_STEPS=20 with an unsatisfiable 2-clause instance (x1)&(~x1) -> `timeout`=1 at step 20, `busy`=0, `best_unsat`=1.
- `start` pulsed during RUN -> ignored: `step_count` keeps counting.
- `start` pulsed in SOLVED -> `solved`=0, `busy`=1, `best_unsat`=80 next cycle.
- With `AMOEBA_BEST_SNAPSHOT_EN`: `best_x` equals the `x` value at which `best_unsat` last decreased.
